// File: rtl/bus_arbiter_pkg.sv
// Shared cache package: bus request types, arbiter states and bus geometry.
// Geometry macros default here unless the surrounding build already set them.
`ifndef CPU_CORES
`define CPU_CORES 4
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_UPGR = 2'd1,
        BUS_WB   = 2'd2
    } bus_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    localparam int DEF_CNT_BITS = 16;
    localparam int LINE_BITS    = `ADDR_BITS - `OFFSET_BITS;
    localparam int CORE_BITS    = (`CPU_CORES > 1) ? $clog2(`CPU_CORES) : 1;

    function automatic logic [CORE_BITS-1:0] next_core(
        input logic [CORE_BITS-1:0] id
    );
        return (int'(id) == `CPU_CORES - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin search: first set valid bit at or cyclically above ptr_i.
// Rotating the request vector turns the search into a fixed priority scan.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int N = `CPU_CORES,
    parameter int W = CORE_BITS
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] ptr_i,
    output logic         hit_o,
    output logic [W-1:0] idx_o
);

    logic [N-1:0] rot;
    int           pos;

    always_comb begin
        rot   = N'({valid_i, valid_i} >> ptr_i);
        hit_o = 1'b0;
        idx_o = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = int'(ptr_i) + k;
                if (pos >= N) pos = pos - N;
                hit_o = 1'b1;
                idx_o = W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter funnelling per-core L1 requests onto the coherence bus,
// with a per-transaction watchdog and saturating per-core grant counters.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = DEF_CNT_BITS
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [`CPU_CORES-1:0]                      l1_req_valid,
    output logic [`CPU_CORES-1:0]                      l1_req_ready,
    input  logic [`CPU_CORES-1:0][LINE_BITS-1:0]       l1_req_addr,
    input  bus_req_t [`CPU_CORES-1:0]                  l1_req,
    input  logic [`CPU_CORES-1:0][`CACHELINE_BITS-1:0] l1_req_data,
    output logic                                       bus_req_valid,
    input  logic                                       bus_req_ready,
    output logic [LINE_BITS-1:0]                       bus_req_addr,
    output bus_req_t                                   bus_req,
    output logic [`CACHELINE_BITS-1:0]                 bus_req_data,
    output logic [CORE_BITS-1:0]                       bus_req_cpu,
    input  logic                                       bus_txn_done,
    output logic [`CPU_CORES-1:0][CNT_BITS-1:0]        grant_count,
    output logic                                       err_timeout
);

    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t                           state_q, state_d;
    logic [CORE_BITS-1:0]                 rr_q, rr_d;
    logic [LINE_BITS-1:0]                 addr_q, addr_d;
    bus_req_t                             req_q, req_d;
    logic [`CACHELINE_BITS-1:0]           data_q, data_d;
    logic [CORE_BITS-1:0]                 cpu_q, cpu_d;
    logic [WD_BITS-1:0]                   wd_q, wd_d;
    logic [`CPU_CORES-1:0][CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                                 err_q, err_d;

    logic                 hit;
    logic [CORE_BITS-1:0] win;
    logic                 grant;

    rr_pick #(
        .N(`CPU_CORES),
        .W(CORE_BITS)
    ) u_pick (
        .valid_i(l1_req_valid),
        .ptr_i  (rr_q),
        .hit_o  (hit),
        .idx_o  (win)
    );

    // Gated by reset_n so no accept pulse escapes while reset is held.
    assign grant = hit && reset_n && (state_q == ARB_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            addr_q  <= '0;
            req_q   <= BUS_RD;
            data_q  <= '0;
            cpu_q   <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cpu_q   <= cpu_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        addr_d       = addr_q;
        req_d        = req_q;
        data_d       = data_q;
        cpu_d        = cpu_q;
        wd_d         = wd_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        l1_req_ready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    l1_req_ready[win] = 1'b1;
                    addr_d  = l1_req_addr[win];
                    req_d   = l1_req[win];
                    data_d  = l1_req_data[win];
                    cpu_d   = win;
                    wd_d    = '0;
                    state_d = ARB_ISSUE;
                    if (cnt_q[win] != '1) cnt_d[win] = cnt_q[win] + 1'b1;
                end
            end
            ARB_ISSUE, ARB_BUSY: begin
                wd_d = wd_q + 1'b1;
                // The watchdog overrides any handshake or done seen this cycle.
                if (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                    rr_d    = next_core(cpu_q);
                end else if (state_q == ARB_ISSUE && bus_req_ready) begin
                    state_d = ARB_BUSY;
                    rr_d    = next_core(cpu_q);
                end else if (state_q == ARB_BUSY && bus_txn_done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus_req_valid = (state_q == ARB_ISSUE);
    assign bus_req_addr  = addr_q;
    assign bus_req       = req_q;
    assign bus_req_data  = data_q;
    assign bus_req_cpu   = cpu_q;
    assign grant_count   = cnt_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: grant-order table, directed corner sequences and
// random traffic compared every cycle against a transaction-level model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = `CPU_CORES;
    localparam int TO = 8;
    localparam int CB = 2;
    localparam int LB = LINE_BITS;
    localparam int DB = `CACHELINE_BITS;

    logic                       clk;
    logic                       reset_n;
    logic [N-1:0]               l1_req_valid;
    logic [N-1:0]               l1_req_ready;
    logic [N-1:0][LB-1:0]       l1_req_addr;
    bus_req_t [N-1:0]           l1_req;
    logic [N-1:0][DB-1:0]       l1_req_data;
    logic                       bus_req_valid;
    logic                       bus_req_ready;
    logic [LB-1:0]              bus_req_addr;
    bus_req_t                   bus_req;
    logic [DB-1:0]              bus_req_data;
    logic [CORE_BITS-1:0]       bus_req_cpu;
    logic                       bus_txn_done;
    logic [N-1:0][CB-1:0]       grant_count;
    logic                       err_timeout;

    bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .CNT_BITS      (CB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .l1_req_valid (l1_req_valid),
        .l1_req_ready (l1_req_ready),
        .l1_req_addr  (l1_req_addr),
        .l1_req       (l1_req),
        .l1_req_data  (l1_req_data),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_addr (bus_req_addr),
        .bus_req      (bus_req),
        .bus_req_data (bus_req_data),
        .bus_req_cpu  (bus_req_cpu),
        .bus_txn_done (bus_txn_done),
        .grant_count  (grant_count),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: one outstanding transaction at a time.
    bit            m_active;
    bit            m_acc;
    int            m_age;
    int            m_rr;
    int            m_cpu;
    logic [LB-1:0] m_addr;
    bus_req_t      m_req;
    logic [DB-1:0] m_data;
    int            m_cnt[N];
    bit            m_err;

    task automatic chk(input string nm, input logic [DB-1:0] act,
                       input logic [DB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_acc    = 0;
        m_age    = 0;
        m_rr     = 0;
        m_cpu    = 0;
        m_addr   = '0;
        m_req    = BUS_RD;
        m_data   = '0;
        m_err    = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (l1_req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [DB-1:0] rand_line();
        logic [DB-1:0] d;
        for (int w = 0; w < DB / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Called just after a falling edge with inputs set; returns at the next one.
    task automatic tick();
        int           w;
        logic [N-1:0] er;
        #1;
        w  = m_active ? -1 : pick();
        er = (w >= 0) ? (N'(1) << w) : '0;
        chk("ready", l1_req_ready, er);
        chk("bus_valid", bus_req_valid, m_active && !m_acc);
        chk("bus_addr", bus_req_addr, m_addr);
        chk("bus_req", bus_req, m_req);
        chk("bus_data", bus_req_data, m_data);
        chk("bus_cpu", bus_req_cpu, m_cpu);
        for (int i = 0; i < N; i++) chk("gcount", grant_count[i], m_cnt[i]);
        chk("err", err_timeout, m_err);
        @(posedge clk);
        if (!m_active) begin
            if (w >= 0) begin
                m_active = 1;
                m_acc    = 0;
                m_age    = 0;
                m_cpu    = w;
                m_addr   = l1_req_addr[w];
                m_req    = l1_req[w];
                m_data   = l1_req_data[w];
                if (m_cnt[w] < (1 << CB) - 1) m_cnt[w]++;
            end
        end else begin
            if (m_age == TO - 1) begin
                m_err    = 1;
                m_active = 0;
                m_rr     = (m_cpu + 1) % N;
            end else if (!m_acc) begin
                if (bus_req_ready) begin
                    m_acc = 1;
                    m_rr  = (m_cpu + 1) % N;
                end
            end else if (bus_txn_done) begin
                m_active = 0;
            end
            m_age++;
        end
        @(negedge clk);
    endtask

    task automatic txn(input logic [N-1:0] v, input int exp_id,
                       input int stall, input int busy);
        logic [N-1:0] er;
        l1_req_valid  = v;
        bus_req_ready = 0;
        bus_txn_done  = 0;
        er = (exp_id >= 0) ? (N'(1) << exp_id) : '0;
        #1 chk("grant_order", l1_req_ready, er);
        tick();
        if (exp_id < 0) return;
        #1 chk("issue_cpu", bus_req_cpu, exp_id);
        chk("issue_valid", bus_req_valid, 1'b1);
        repeat (stall) tick();
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;
        repeat (busy - 1) tick();
        bus_txn_done = 1;
        tick();
        bus_txn_done = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, l1_req_ready, '0);
        chk({nm, "_bvalid"}, bus_req_valid, '0);
        chk({nm, "_addr"}, bus_req_addr, '0);
        chk({nm, "_req"}, bus_req, BUS_RD);
        chk({nm, "_data"}, bus_req_data, '0);
        chk({nm, "_cpu"}, bus_req_cpu, '0);
        chk({nm, "_gcount"}, grant_count, '0);
        chk({nm, "_err"}, err_timeout, '0);
    endtask

    typedef struct {
        logic [N-1:0] v;
        int           exp;
    } vec_t;

    vec_t          tbl[10];
    logic [LB-1:0] a3;

    initial begin
        tbl[0] = '{4'b1111, 1};
        tbl[1] = '{4'b0001, 0};
        tbl[2] = '{4'b1000, 3};
        tbl[3] = '{4'b0110, 1};
        tbl[4] = '{4'b0101, 2};
        tbl[5] = '{4'b0101, 0};
        tbl[6] = '{4'b1010, 1};
        tbl[7] = '{4'b1010, 3};
        tbl[8] = '{4'b0000, -1};
        tbl[9] = '{4'b1100, 2};

        reset_n       = 0;
        l1_req_valid  = '1;
        bus_req_ready = 0;
        bus_txn_done  = 0;
        for (int i = 0; i < N; i++) begin
            l1_req_addr[i] = LB'($urandom);
            l1_req_data[i] = rand_line();
            l1_req[i]      = bus_req_t'(i % 3);
        end
        model_reset();
        @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        reset_n      = 1;
        l1_req_valid = '0;

        // Four cores always requesting: strict rotation from core 0.
        for (int i = 0; i < N; i++) txn(4'b1111, i, 0, 2);
        for (int i = 0; i < N; i++) chk("rot_gcount", grant_count[i], 1);
        txn(4'b1111, 0, 0, 2);

        for (int t = 0; t < 10; t++) txn(tbl[t].v, tbl[t].exp, t % 3, 1 + t % 2);

        // Lone requester below the pointer wraps around to it.
        l1_req_valid = 4'b0100;
        #1 chk("lone_ready", l1_req_ready, 4'b0100);
        tick();
        #1 chk("lone_valid", bus_req_valid, 1'b1);
        chk("lone_cpu", bus_req_cpu, 2);
        chk("lone_addr", bus_req_addr, l1_req_addr[2]);
        chk("lone_data", bus_req_data, l1_req_data[2]);
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;
        bus_txn_done  = 1;
        tick();
        bus_txn_done  = 0;

        // Stalled issue: held fields ignore later changes on the source core.
        a3           = l1_req_addr[3];
        l1_req_valid = 4'b1111;
        tick();
        l1_req_addr[3] = ~a3;
        for (int s = 0; s < 5; s++) begin
            #1 chk("stall_ready", l1_req_ready, '0);
            chk("stall_valid", bus_req_valid, 1'b1);
            chk("stall_addr", bus_req_addr, a3);
            tick();
        end
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;
        bus_txn_done  = 1;
        tick();
        bus_txn_done  = 0;
        l1_req_addr[3] = a3;

        for (int t = 0; t < 5; t++) txn(4'b0001, 0, 0, 1);
        #1 chk("sat_gcount0", grant_count[0], 2'b11);

        // Watchdog: handshake then no done for the rest of the budget.
        l1_req_valid = 4'b0010;
        tick();
        l1_req_valid  = 4'b1111;
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;
        repeat (TO - 2) tick();
        #1 chk("wd_err_early", err_timeout, 1'b0);
        tick();
        #1 chk("wd_err", err_timeout, 1'b1);
        chk("wd_next_grant", l1_req_ready, 4'b0100);
        tick();
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;

        // Reset while busy clears everything at once.
        reset_n = 0;
        #1 chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 chk_all_zero("midrst_hold");
        @(negedge clk);
        reset_n      = 1;
        l1_req_valid = 4'b0010;
        #1 chk("rel_ready", l1_req_ready, 4'b0010);
        tick();
        #1 chk("rel_cpu", bus_req_cpu, 1);
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0;
        bus_txn_done  = 1;
        tick();

        for (int c = 0; c < 800; c++) begin
            l1_req_valid  = N'($urandom);
            bus_req_ready = ($urandom_range(0, 2) != 0);
            bus_txn_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, N - 1);
                l1_req_addr[j] = LB'($urandom);
                l1_req_data[j] = rand_line();
                l1_req[j]      = bus_req_t'($urandom_range(0, 2));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
